// File: rtl/pokey_timer_pair.sv
// One POKEY audio timer pair: two 8-bit countdown channels that can be linked into one 16-bit channel.
// Optional interrupt flags are enabled by defining TIMER_IRQ_EN.
module pokey_timer_pair #(
    parameter int FAST_ADJ_8  = 3,
    parameter int FAST_ADJ_16 = 6
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable_179,
    input  logic       enable_base,
    input  logic       sel_fast_lo,
    input  logic       sel_fast_hi,
    input  logic       link,
    input  logic       audf_lo_wr,
    input  logic       audf_hi_wr,
    input  logic [7:0] data_in,
    input  logic       stimer_wr,
    input  logic       init,
    output logic       out_lo_pulse,
    output logic       out_hi_pulse,
    output logic       out_lo_sq,
`ifdef TIMER_IRQ_EN
    output logic       out_hi_sq,
    input  logic [1:0] irq_clr,
    output logic [1:0] irq
`else
    output logic       out_hi_sq
`endif
);

    logic [7:0]  audf_lo_q, audf_lo_d;
    logic [7:0]  audf_hi_q, audf_hi_d;
    logic [16:0] cnt_lo_q, cnt_lo_d;
    logic [8:0]  cnt_hi_q, cnt_hi_d;
    logic        lo_pulse_q, lo_pulse_d;
    logic        hi_pulse_q, hi_pulse_d;
    logic        lo_sq_q, lo_sq_d;
    logic        hi_sq_q, hi_sq_d;
    logic        en_lo, en_hi;

    function automatic logic [8:0] reload8(input logic [7:0] audf, input logic fast);
        return {1'b0, audf} + (fast ? 9'(FAST_ADJ_8) : 9'd0);
    endfunction

    function automatic logic [16:0] reload16(input logic [7:0] hi, input logic [7:0] lo,
                                             input logic fast);
        return {1'b0, hi, lo} + (fast ? 17'(FAST_ADJ_16) : 17'd0);
    endfunction

    // The lo counter is 17 bits so it can carry the whole linked count; unlinked it keeps only 9 bits.
    always_comb begin
        audf_lo_d  = audf_lo_wr ? data_in : audf_lo_q;
        audf_hi_d  = audf_hi_wr ? data_in : audf_hi_q;
        en_lo      = sel_fast_lo ? enable_179 : enable_base;
        en_hi      = sel_fast_hi ? enable_179 : enable_base;
        cnt_lo_d   = link ? cnt_lo_q : {8'd0, cnt_lo_q[8:0]};
        cnt_hi_d   = cnt_hi_q;
        lo_pulse_d = 1'b0;
        hi_pulse_d = 1'b0;
        lo_sq_d    = lo_sq_q;
        hi_sq_d    = hi_sq_q;

        if (init || stimer_wr) begin
            cnt_lo_d = link ? reload16(audf_hi_d, audf_lo_d, sel_fast_lo)
                            : {8'd0, reload8(audf_lo_d, sel_fast_lo)};
            cnt_hi_d = reload8(audf_hi_d, sel_fast_hi);
            if (stimer_wr) begin
                lo_sq_d = 1'b0;
                hi_sq_d = 1'b0;
            end
        end else if (link) begin
            if (en_lo) begin
                if (cnt_lo_q == 17'd0) begin
                    cnt_lo_d   = reload16(audf_hi_q, audf_lo_q, sel_fast_lo);
                    hi_pulse_d = 1'b1;
                    hi_sq_d    = ~hi_sq_q;
                end else begin
                    cnt_lo_d = cnt_lo_q - 17'd1;
                end
            end
        end else begin
            if (en_lo) begin
                if (cnt_lo_q[8:0] == 9'd0) begin
                    cnt_lo_d   = {8'd0, reload8(audf_lo_q, sel_fast_lo)};
                    lo_pulse_d = 1'b1;
                    lo_sq_d    = ~lo_sq_q;
                end else begin
                    cnt_lo_d = {8'd0, cnt_lo_q[8:0] - 9'd1};
                end
            end
            if (en_hi) begin
                if (cnt_hi_q == 9'd0) begin
                    cnt_hi_d   = reload8(audf_hi_q, sel_fast_hi);
                    hi_pulse_d = 1'b1;
                    hi_sq_d    = ~hi_sq_q;
                end else begin
                    cnt_hi_d = cnt_hi_q - 9'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            audf_lo_q  <= 8'd0;
            audf_hi_q  <= 8'd0;
            cnt_lo_q   <= 17'd0;
            cnt_hi_q   <= 9'd0;
            lo_pulse_q <= 1'b0;
            hi_pulse_q <= 1'b0;
            lo_sq_q    <= 1'b0;
            hi_sq_q    <= 1'b0;
        end else begin
            audf_lo_q  <= audf_lo_d;
            audf_hi_q  <= audf_hi_d;
            cnt_lo_q   <= cnt_lo_d;
            cnt_hi_q   <= cnt_hi_d;
            lo_pulse_q <= lo_pulse_d;
            hi_pulse_q <= hi_pulse_d;
            lo_sq_q    <= lo_sq_d;
            hi_sq_q    <= hi_sq_d;
        end
    end

    assign out_lo_pulse = lo_pulse_q;
    assign out_hi_pulse = hi_pulse_q;
    assign out_lo_sq    = lo_sq_q;
    assign out_hi_sq    = hi_sq_q;

`ifdef TIMER_IRQ_EN
    logic [1:0] irq_q, irq_d;

    // Flags rise together with the pulse outputs; a set beats a clear in the same cycle.
    always_comb begin
        irq_d = irq_q & ~irq_clr;
        if (lo_pulse_d) irq_d[0] = 1'b1;
        if (hi_pulse_d) irq_d[1] = 1'b1;
        if (init)       irq_d    = 2'b00;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) irq_q <= 2'b00;
        else          irq_q <= irq_d;
    end

    assign irq = irq_q;
`endif

endmodule

// File: tb/tb_pokey_timer_pair.sv
// Self-checking bench for pokey_timer_pair: vector table of timer configurations plus corner-case sequences.
// Expected pulse intervals go into per-channel queues and are compared as pulses appear.
module tb_pokey_timer_pair;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable_179 = 1'b0;
    logic       enable_base = 1'b0;
    logic       sel_fast_lo = 1'b0;
    logic       sel_fast_hi = 1'b0;
    logic       link = 1'b0;
    logic       audf_lo_wr = 1'b0;
    logic       audf_hi_wr = 1'b0;
    logic [7:0] data_in = 8'd0;
    logic       stimer_wr = 1'b0;
    logic       init = 1'b0;
    logic       out_lo_pulse, out_hi_pulse, out_lo_sq, out_hi_sq;
`ifdef TIMER_IRQ_EN
    logic [1:0] irq_clr = 2'b00;
    logic [1:0] irq;
`endif

    pokey_timer_pair dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable_179  (enable_179),
        .enable_base (enable_base),
        .sel_fast_lo (sel_fast_lo),
        .sel_fast_hi (sel_fast_hi),
        .link        (link),
        .audf_lo_wr  (audf_lo_wr),
        .audf_hi_wr  (audf_hi_wr),
        .data_in     (data_in),
        .stimer_wr   (stimer_wr),
        .init        (init),
        .out_lo_pulse(out_lo_pulse),
        .out_hi_pulse(out_hi_pulse),
        .out_lo_sq   (out_lo_sq),
`ifdef TIMER_IRQ_EN
        .out_hi_sq   (out_hi_sq),
        .irq_clr     (irq_clr),
        .irq         (irq)
`else
        .out_hi_sq   (out_hi_sq)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] audf_lo;
        logic [7:0] audf_hi;
        bit         fast_lo;
        bit         fast_hi;
        bit         lnk;
        int         kb;
        int         exp_lo;
        int         exp_hi;
        int         cycles;
    } vec_t;

    vec_t vecs[6];
    int   exp_lo_q[$];
    int   exp_hi_q[$];
    int   last_lo = 0, last_hi = 0;
    bit   exp_sq_lo = 1'b0, exp_sq_hi = 1'b0;
    bit   lo_silent = 1'b0, hi_silent = 1'b0;
    int   n_cmp = 0, n_fail = 0;

    task automatic checkValue(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Sampled on the falling edge: pulses are matched against the queued intervals.
    task automatic checkOutput();
        int e;
        if (out_lo_pulse) begin
            if (lo_silent) checkValue("lo_pulse_silent", 1, 0);
            exp_sq_lo = ~exp_sq_lo;
            if (exp_lo_q.size() > 0) begin
                e = exp_lo_q.pop_front();
                checkValue("lo_period", cyc - last_lo, e);
                checkValue("lo_sq", int'(out_lo_sq), int'(exp_sq_lo));
`ifdef TIMER_IRQ_EN
                checkValue("irq0_on_pulse", int'(irq[0]), 1);
`endif
            end
            last_lo = cyc;
        end
        if (out_hi_pulse) begin
            if (hi_silent) checkValue("hi_pulse_silent", 1, 0);
            exp_sq_hi = ~exp_sq_hi;
            if (exp_hi_q.size() > 0) begin
                e = exp_hi_q.pop_front();
                checkValue("hi_period", cyc - last_hi, e);
                checkValue("hi_sq", int'(out_hi_sq), int'(exp_sq_hi));
`ifdef TIMER_IRQ_EN
                checkValue("irq1_on_pulse", int'(irq[1]), 1);
`endif
            end
            last_hi = cyc;
        end
    endtask

    task automatic applyStimulus(input bit st, input bit iv, input bit wl, input bit wh,
                                 input logic [7:0] d, input bit ef, input bit eb);
        @(negedge clk);
        checkOutput();
        if (st) begin
            last_lo   = cyc + 1;
            last_hi   = cyc + 1;
            exp_sq_lo = 1'b0;
            exp_sq_hi = 1'b0;
        end
        if (init && !iv) begin
            last_lo = cyc;
            last_hi = cyc;
        end
        stimer_wr   = st;
        init        = iv;
        audf_lo_wr  = wl;
        audf_hi_wr  = wh;
        data_in     = d;
        enable_179  = ef;
        enable_base = eb;
    endtask

    task automatic runCycles(input int n, input int kb);
        for (int j = 1; j <= n; j++) applyStimulus(0, 0, 0, 0, 8'd0, 1'b1, (j % kb) == 0);
    endtask

    task automatic writeRegs(input logic [7:0] lo, input logic [7:0] hi);
        applyStimulus(0, 0, 1, 0, lo, 0, 0);
        applyStimulus(0, 0, 0, 1, hi, 0, 0);
    endtask

    task automatic finishSegment(input string name);
        checkValue({name, "_lo_pending"}, exp_lo_q.size(), 0);
        checkValue({name, "_hi_pending"}, exp_hi_q.size(), 0);
        exp_lo_q.delete();
        exp_hi_q.delete();
    endtask

    task automatic pushN(input int lo, input int hi, input int n);
        for (int i = 0; i < n; i++) begin
            if (lo != 0) exp_lo_q.push_back(lo);
            if (hi != 0) exp_hi_q.push_back(hi);
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        //           lo     hi     flo   fhi   lnk   kb  explo exphi cycles
        vecs[0] = '{8'd4,  8'd0,  1'b0, 1'b1, 1'b0, 28, 140,  4,   430};
        vecs[1] = '{8'd9,  8'd2,  1'b0, 1'b0, 1'b0, 1,  10,   3,   40};
        vecs[2] = '{8'd5,  8'd3,  1'b1, 1'b0, 1'b0, 3,  9,    12,  50};
        vecs[3] = '{8'd0,  8'd1,  1'b1, 1'b0, 1'b1, 5,  0,    263, 800};
        vecs[4] = '{8'd3,  8'd0,  1'b0, 1'b1, 1'b1, 2,  0,    8,   40};
        vecs[5] = '{8'd255, 8'd255, 1'b1, 1'b1, 1'b0, 7, 259, 259, 800};

        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checkValue("reset_lo_pulse", int'(out_lo_pulse), 0);
        checkValue("reset_hi_pulse", int'(out_hi_pulse), 0);
        checkValue("reset_lo_sq", int'(out_lo_sq), 0);
        checkValue("reset_hi_sq", int'(out_hi_sq), 0);
`ifdef TIMER_IRQ_EN
        checkValue("reset_irq", int'(irq), 0);
`endif

        foreach (vecs[i]) begin
            writeRegs(vecs[i].audf_lo, vecs[i].audf_hi);
            sel_fast_lo = vecs[i].fast_lo;
            sel_fast_hi = vecs[i].fast_hi;
            link        = vecs[i].lnk;
            applyStimulus(1, 0, 0, 0, 8'd0, 0, 0);
            lo_silent = (vecs[i].exp_lo == 0);
            hi_silent = (vecs[i].exp_hi == 0);
            pushN(vecs[i].exp_lo, vecs[i].exp_hi, 3);
            runCycles(vecs[i].cycles, vecs[i].kb);
            finishSegment($sformatf("vec%0d", i));
        end
        lo_silent = 1'b0;
        hi_silent = 1'b0;

        // AUDF rewritten mid-count: current period keeps the old reload.
        writeRegs(8'd9, 8'd255);
        sel_fast_lo = 1'b0;
        sel_fast_hi = 1'b0;
        link        = 1'b0;
        applyStimulus(1, 0, 0, 0, 8'd0, 0, 0);
        exp_lo_q.push_back(10);
        exp_lo_q.push_back(3);
        exp_lo_q.push_back(3);
        runCycles(3, 1);
        applyStimulus(0, 0, 1, 0, 8'd2, 1, 1);
        runCycles(20, 1);
        finishSegment("midwrite");

        // stimer_wr landing on an underflow enable.
        writeRegs(8'd2, 8'd2);
        applyStimulus(1, 0, 0, 0, 8'd0, 0, 0);
        pushN(3, 3, 2);
        runCycles(8, 1);
        finishSegment("coll_pre");
        applyStimulus(1, 0, 0, 0, 8'd0, 1, 1);
        @(posedge clk);
        #1;
        checkValue("coll_lo_pulse", int'(out_lo_pulse), 0);
        checkValue("coll_hi_pulse", int'(out_hi_pulse), 0);
        checkValue("coll_lo_sq", int'(out_lo_sq), 0);
        checkValue("coll_hi_sq", int'(out_hi_sq), 0);
        pushN(3, 3, 1);
        runCycles(6, 1);
        finishSegment("coll_post");

        // init hold, then restart from the reload values.
        writeRegs(8'd4, 8'd1);
        applyStimulus(1, 0, 0, 0, 8'd0, 0, 0);
        runCycles(7, 1);
        applyStimulus(0, 0, 0, 0, 8'd0, 0, 0);
`ifdef TIMER_IRQ_EN
        checkValue("irq_sticky", int'(irq), 3);
        irq_clr = 2'b11;
        @(posedge clk);
        #1;
        checkValue("irq_cleared", int'(irq), 0);
        irq_clr = 2'b00;
        applyStimulus(0, 0, 0, 0, 8'd0, 1, 1);
`endif
        applyStimulus(0, 1, 0, 0, 8'd0, 1, 1);
        lo_silent = 1'b1;
        hi_silent = 1'b1;
        for (int i = 0; i < 6; i++) applyStimulus(0, 1, 0, 0, 8'd0, 1, 1);
        @(posedge clk);
        #1;
        checkValue("init_lo_sq_held", int'(out_lo_sq), int'(exp_sq_lo));
        checkValue("init_hi_sq_held", int'(out_hi_sq), int'(exp_sq_hi));
`ifdef TIMER_IRQ_EN
        checkValue("init_irq", int'(irq), 0);
`endif
        applyStimulus(0, 0, 0, 0, 8'd0, 1, 1);
        lo_silent = 1'b0;
        hi_silent = 1'b0;
        exp_lo_q.push_back(5);
        exp_hi_q.push_back(2);
        runCycles(10, 1);
        finishSegment("init");

        // Reset while a pulse is on the outputs.
        writeRegs(8'd5, 8'd5);
        applyStimulus(1, 0, 0, 0, 8'd0, 0, 0);
        runCycles(6, 1);
        @(negedge clk);
        enable_179  = 1'b0;
        enable_base = 1'b0;
        reset_n     = 1'b0;
        #1;
        checkValue("rst_lo_pulse", int'(out_lo_pulse), 0);
        checkValue("rst_hi_pulse", int'(out_hi_pulse), 0);
        checkValue("rst_lo_sq", int'(out_lo_sq), 0);
        checkValue("rst_hi_sq", int'(out_hi_sq), 0);
`ifdef TIMER_IRQ_EN
        checkValue("rst_irq", int'(irq), 0);
`endif
        @(negedge clk);
        reset_n   = 1'b1;
        exp_sq_lo = 1'b0;
        exp_sq_hi = 1'b0;
        @(posedge clk);
        #1;
        checkValue("rst_no_pending_lo", int'(out_lo_pulse), 0);
        checkValue("rst_no_pending_hi", int'(out_hi_pulse), 0);
        sel_fast_lo = 1'b1;
        sel_fast_hi = 1'b1;
        applyStimulus(1, 0, 0, 0, 8'd0, 0, 0);
        pushN(4, 4, 2);
        runCycles(12, 1);
        finishSegment("rst_audf");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pokey_timer_pair.md
Name: pokey_timer_pair

Overview:
Downstream consumer of the POKEY clock-enable dividers. Implements one POKEY audio timer pair: two 8-bit countdown channels (lo/hi). The pair can be linked into one 16-bit channel. Each channel is clocked by either the 1.79 MHz enable or the selected base enable (64 kHz/15 kHz). It produces underflow pulses and square-wave outputs for the poly/noise and volume stages.

Parameters:
FAST_ADJ_8, 3, extra counts added to the reload value for an unlinked channel on 1.79 MHz clock (period = AUDF+4)
FAST_ADJ_16, 6, extra counts added to the reload value for the linked pair on 1.79 MHz clock (period = AUDF16+7)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
enable_179  in  1  1.79 MHz clock-enable pulse, one clk wide
enable_base  in  1  base clock-enable pulse (64k/15k already selected upstream), one clk wide
sel_fast_lo  in  1  1 = lo channel (or the linked pair) uses enable_179
sel_fast_hi  in  1  1 = hi channel uses enable_179; ignored when linked
link  in  1  1 = hi:lo form one 16-bit counter
audf_lo_wr  in  1  write strobe, AUDF lo register
audf_hi_wr  in  1  write strobe, AUDF hi register
data_in  in  8  register write data
stimer_wr  in  1  restart both counters
init  in  1  synchronous hold (POKEY init state)
out_lo_pulse  out  1  lo underflow pulse, one clk
out_hi_pulse  out  1  hi underflow pulse, one clk
out_lo_sq  out  1  lo square output
out_hi_sq  out  1  hi square output

Behaviour:
- Reset: AUDF regs = 0x00, counters = 0, all outputs 0. Reset mid-count aborts immediately; there is no pending pulse after release.
- Channel enable: en_lo = sel_fast_lo ? enable_179 : enable_base. en_hi (unlinked) is chosen the same way using sel_fast_hi.
- Reload values, unlinked:
  - R = AUDF + (fast ? FAST_ADJ_8 : 0).
  - Counter width is 9 bits.
- Reload value, linked:
  - R16 = {AUDF_hi,AUDF_lo} + (sel_fast_lo ? FAST_ADJ_16 : 0).
  - The pair counts as one 17-bit counter on en_lo.
- Counting: on each enable cycle, if count == 0 the counter loads R and fires an underflow; otherwise it decrements. Period = R+1 enables.
- Output timing:
  - Underflow is registered: the pulse output is high for exactly one clk, in the cycle after the enable cycle that underflowed.
  - The square output toggles in that same cycle.
- Linked mode: only the hi outputs are active (out_hi_pulse, out_hi_sq). out_lo_pulse is held 0 and out_lo_sq holds its value.
- Switching link or a select mid-count: takes effect on the next enable. The current count is kept, truncated or zero-extended to the new width.
- AUDF writes:
  - The register updates in the cycle after the strobe.
  - The running count is unaffected; the new value applies at the next reload.
- stimer_wr:
  - Next cycle, both counters load their current reload values. If an AUDF write occurs in the same cycle, its data is used.
  - Square outputs clear to 0.
  - An underflow in the same cycle is suppressed (no pulse).
- init = 1: counters are held at their reload values, with no pulses and no toggles. Counting resumes on the first enable after init deasserts.
- Simultaneous enable_179 and enable_base: each channel uses only its selected source, so there is no double count.

Optional Feature:
TIMER_IRQ_EN:
- When defined, adds input irq_clr[1:0] and output irq[1:0].
- irq[0] sets on a lo underflow pulse; irq[1] sets on a hi pulse, which includes the linked-mode pulse.
- Each bit is sticky until its irq_clr bit is seen high. Set wins over clear in the same cycle.
- Reset and init clear both bits.
- When not defined, the ports and logic are absent.

Test Plan:
- Unlinked slow: AUDF_lo=4, sel_fast_lo=0, enable_base every 28 clks -> out_lo_pulse every 140 clks; out_lo_sq period 280 clks.
- Unlinked fast: AUDF_hi=0, sel_fast_hi=1, enable_179 every clk -> out_hi_pulse every 4 clks; out_hi_sq toggles every 4 clks.
- Linked fast: AUDF lo=0x00, hi=0x01, link=1, sel_fast_lo=1, enable_179 every clk -> out_hi_pulse every 263 clks; out_lo_pulse stays 0.
- Mid-count write: AUDF_lo=9 running on enable_base every clk, write 2 after 3 enables -> current period still 10 clks, following periods 3 clks.
- Collision: stimer_wr in the same cycle as an underflow enable -> no pulse; both counters restart at R; square outputs = 0.
- Reset mid-count: reset_n low for 1 clk during an AUDF=5 run -> all outputs 0 and AUDF=0x00. With TIMER_IRQ_EN, irq=2'b00 after reset.
